// File: rtl/alarm_comp.sv
// Alarm comparator: rings alerm_output for ring_seconds seconds on each new
// qualified match between the running time word and the stored alarm word.
module alarm_comp #(
    parameter int unsigned second_cnt   = 50_000_000,
    parameter int unsigned ring_seconds = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] timer_data,
    input  logic [17:0] alerm_data,
    input  logic        alerm_enable,
    output logic        alerm_output
);

    localparam int unsigned PRE_W = (second_cnt   > 1) ? $clog2(second_cnt)   : 1;
    localparam int unsigned SEC_W = (ring_seconds > 1) ? $clog2(ring_seconds) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(second_cnt - 1);
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(ring_seconds - 1);

    typedef enum logic {
        IDLE,
        RING
    } state_t;

    state_t             state, state_next;
    logic [PRE_W-1:0]   prescaler, prescaler_next;
    logic [SEC_W-1:0]   seconds, seconds_next;
    logic               match, match_prev, trigger;

    assign match   = alerm_enable && (timer_data == alerm_data);
    assign trigger = match && !match_prev;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            prescaler  <= '0;
            seconds    <= '0;
            match_prev <= 1'b0;
        end else begin
            state      <= state_next;
            prescaler  <= prescaler_next;
            seconds    <= seconds_next;
            match_prev <= match;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        seconds_next   = seconds;

        if (!alerm_enable) begin
            state_next     = IDLE;
            prescaler_next = '0;
            seconds_next   = '0;
        end else if (trigger) begin
            // A fresh match restarts the full ring even if one is in progress.
            state_next     = RING;
            prescaler_next = '0;
            seconds_next   = '0;
        end else if (state == RING) begin
            if (prescaler == PRE_MAX) begin
                prescaler_next = '0;
                if (seconds == SEC_MAX) begin
                    state_next   = IDLE;
                    seconds_next = '0;
                end else begin
                    seconds_next = seconds + 1'b1;
                end
            end else begin
                prescaler_next = prescaler + 1'b1;
            end
        end
    end

    assign alerm_output = (state == RING);

endmodule

// File: tb/tb_alarm_comp.sv
// Directed bench for alarm_comp with a 4-cycle second and a 60-second ring,
// so one ring lasts 240 clock cycles.
`timescale 1ns/1ps
module tb_alarm_comp;

    localparam int SECOND_CNT   = 4;
    localparam int RING_SECONDS = 60;
    localparam int RING_LEN     = SECOND_CNT * RING_SECONDS;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] timer_data;
    logic [17:0] alerm_data;
    logic        alerm_enable;
    logic        alerm_output;

    int tests_run    = 0;
    int tests_failed = 0;

    alarm_comp #(
        .second_cnt  (SECOND_CNT),
        .ring_seconds(RING_SECONDS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .timer_data  (timer_data),
        .alerm_data  (alerm_data),
        .alerm_enable(alerm_enable),
        .alerm_output(alerm_output)
    );

    always #1 clock = ~clock;

    // Advance one active edge and settle half a period before sampling.
    task automatic step();
        @(posedge clock);
        #0.5;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        alerm_enable = 1'b1;
        timer_data   = 18'd1;
        alerm_data   = 18'd1;
        for (int k = 0; k < 32; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: got %b want 0", k, alerm_output);
            end
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (alerm_output !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_trigger: got %b want 1", alerm_output);
        end
    endtask

    task automatic test_disarmed();
        alerm_enable = 1'b0;
        timer_data   = 18'd0;
        alerm_data   = 18'd1;
        step();
        tests_run++;
        if (alerm_output !== 1'b0) begin
            tests_failed++;
            $display("FAIL disarm_clear: got %b want 0", alerm_output);
        end
        timer_data = 18'd1;
        for (int k = 0; k < 10; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b0) begin
                tests_failed++;
                $display("FAIL disarmed_match cycle %0d: got %b want 0", k, alerm_output);
            end
        end
    endtask

    task automatic test_single_ring();
        timer_data   = 18'd0;
        alerm_enable = 1'b1;
        step();
        step();
        tests_run++;
        if (alerm_output !== 1'b0) begin
            tests_failed++;
            $display("FAIL armed_idle: got %b want 0", alerm_output);
        end
        timer_data = 18'd1;
        for (int k = 1; k <= RING_LEN + 1; k++) begin
            if (k == 5) timer_data = 18'd0;
            step();
            tests_run++;
            if (alerm_output !== logic'(k <= RING_LEN)) begin
                tests_failed++;
                $display("FAIL single_ring edge %0d: got %b want %b", k, alerm_output, k <= RING_LEN);
            end
        end
        for (int k = 0; k < 40; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b0) begin
                tests_failed++;
                $display("FAIL after_ring cycle %0d: got %b want 0", k, alerm_output);
            end
        end
    endtask

    task automatic test_held_match();
        timer_data = 18'd1;
        for (int k = 1; k <= 300; k++) begin
            step();
            tests_run++;
            if (alerm_output !== logic'(k <= RING_LEN)) begin
                tests_failed++;
                $display("FAIL held_match edge %0d: got %b want %b", k, alerm_output, k <= RING_LEN);
            end
        end
        timer_data = 18'd0;
        step();
        step();
    endtask

    task automatic test_disable_mid_ring();
        timer_data = 18'd1;
        for (int k = 1; k <= 10; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b1) begin
                tests_failed++;
                $display("FAIL pre_disable edge %0d: got %b want 1", k, alerm_output);
            end
        end
        alerm_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b0) begin
                tests_failed++;
                $display("FAIL disabled edge %0d: got %b want 0", k, alerm_output);
            end
        end
        alerm_enable = 1'b1;
        for (int k = 1; k <= RING_LEN + 1; k++) begin
            step();
            tests_run++;
            if (alerm_output !== logic'(k <= RING_LEN)) begin
                tests_failed++;
                $display("FAIL reenable_ring edge %0d: got %b want %b", k, alerm_output, k <= RING_LEN);
            end
        end
    endtask

    task automatic test_back_to_back();
        timer_data = 18'd0;
        step();
        step();
        timer_data = 18'd1;
        for (int k = 1; k <= 20; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b1) begin
                tests_failed++;
                $display("FAIL first_trigger edge %0d: got %b want 1", k, alerm_output);
            end
        end
        timer_data = 18'd0;
        for (int k = 1; k <= 4; k++) begin
            step();
            tests_run++;
            if (alerm_output !== 1'b1) begin
                tests_failed++;
                $display("FAIL mismatch_ringing edge %0d: got %b want 1", k, alerm_output);
            end
        end
        timer_data = 18'd1;
        for (int k = 1; k <= RING_LEN + 1; k++) begin
            step();
            tests_run++;
            if (alerm_output !== logic'(k <= RING_LEN)) begin
                tests_failed++;
                $display("FAIL restart_ring edge %0d: got %b want %b", k, alerm_output, k <= RING_LEN);
            end
        end
    endtask

    task automatic test_reset_mid_ring();
        timer_data = 18'd0;
        step();
        timer_data = 18'd1;
        step();
        tests_run++;
        if (alerm_output !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_ring: got %b want 1", alerm_output);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (alerm_output !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: got %b want 0", alerm_output);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (alerm_output !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_retrigger: got %b want 1", alerm_output);
        end
    endtask

    initial begin
        test_reset();
        test_disarmed();
        test_single_ring();
        test_held_match();
        test_disable_mid_ring();
        test_back_to_back();
        test_reset_mid_ring();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
